mips_multicycle_ctrl: RTL
=========================

Name: mips_multicycle_ctrl

Overview:
- Main control FSM for the multicycle MIPS datapath; sits directly upstream of the ALU control stage.
- Decodes the 6-bit opcode and sequences fetch, decode, execute, memory and writeback states.
- Drives datapath mux selects and write enables, plus the 2-bit aluop consumed downstream.
- Aluop encoding: 00 = add, 01 = subtract, 10 = use funct field.
- Supports a memory ready handshake so that memory accesses can take wait states.

Parameters:
- OPW, 6, opcode width.
- STW, 4, state register width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- opcode  in  6  instruction[31:26] from the IR; valid from DECODE onward.
- zero  in  1  ALU zero flag; used only by BEQ through pc_write_cond.
- mem_ready  in  1  memory completes the current access at this edge.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load when zero=1.
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- mem_to_reg  out  1  register write data select: 1 = MDR.
- ir_write  out  1  IR load.
- reg_dst  out  1  destination register select: 1 = rd, 0 = rt.
- reg_write  out  1  register file write.
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = A register.
- alu_src_b  out  2  ALU B select: 00 = B, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm << 2.
- aluop  out  2  to ALU control.
- pc_source  out  2  PC source select: 00 = ALU, 01 = ALUOut, 10 = jump target.
- instr_done  out  1  one-cycle pulse in the final state of each instruction.
- illegal_op  out  1  high during DECODE when the opcode is unsupported.
- state  out  STW  current state, for debug.

Behaviour:
- Moore FSM with registered state. Outputs are combinational from state; memory-state enables are qualified by mem_ready as listed below. Any output not listed for a state is 0.
- Reset: rst_n=0 forces state to FETCH asynchronously. While rst_n=0, pc_write, ir_write, mem_write and reg_write are forced to 0. The first fetch starts at the first rising edge after release. Reset asserted mid-instruction abandons that instruction; no partial writeback occurs.
- Opcodes: R-type 000000, LW 100011, SW 101011, BEQ 000100, J 000010.
- FETCH (0):
  - mem_read=1, alu_src_b=01, aluop=00.
  - ir_write = pc_write = mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE (1):
  - alu_src_b=11, aluop=00 (branch target precompute).
  - Next state: LW/SW -> MEMADR, R -> EXEC, BEQ -> BEQ, J -> JUMP.
  - Any other opcode -> FETCH with illegal_op=1 and instr_done=1.
- MEMADR (2): alu_src_a=1, alu_src_b=10, aluop=00. Next: MEMRD for LW, MEMWR for SW.
- MEMRD (3): mem_read=1, iord=1. Waits for mem_ready=1, then MEMWB.
- MEMWB (4): reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1. Next: FETCH.
- MEMWR (5): mem_write=1, iord=1. Waits for mem_ready=1. On the ready edge: instr_done=1, next FETCH.
- EXEC (6): alu_src_a=1, alu_src_b=00, aluop=10. Next: RTWB.
- RTWB (7): reg_write=1, reg_dst=1, instr_done=1. Next: FETCH.
- BEQ (8): alu_src_a=1, aluop=01, pc_write_cond=1, pc_source=01, instr_done=1. Next: FETCH.
- JUMP (9): pc_write=1, pc_source=10, instr_done=1. Next: FETCH.
- Unused state encodings recover to FETCH on the next edge.
- mem_read and mem_write are held stable until mem_ready is sampled high. mem_ready is ignored in non-memory states.
- Latency with zero wait states: LW 5, SW 4, R 4, BEQ 3, J 3 cycles.
- Each wait cycle adds exactly 1 cycle.

Optional Feature:
- Macro CTRL_ADDI_EN.
- When defined: opcode 001000 (ADDI) is decoded to ADDIEX (10), then ADDIWB (11).
  - ADDIEX: alu_src_a=1, alu_src_b=10, aluop=00.
  - ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1; then FETCH.
  - ADDI latency is 4 cycles.
- When undefined: 001000 is illegal (illegal_op=1, return to FETCH), and state encodings 10 and 11 are unused.

Decomposition:
- Shared package mips_pkg:
  - Opcode constants.
  - State encoding constants.
  - aluop constants (ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNC=10), shared with ALU control.
  - alu_src_b and pc_source select constants.
- One natural sub-module: ctrl_output_decode, a pure state-to-output mapping. The FSM top holds the state register, next-state logic, mem_ready qualification and reset forcing.

Test Plan:
- Reset held low for 3 cycles, then released, mem_ready=1: state=0, all write enables 0 during reset. Cycle 1 after release: ir_write=1, pc_write=1.
- LW (100011), mem_ready=1 throughout: states 0,1,2,3,4. aluop sequence 00,00,00. instr_done only in state 4 with reg_write=1, mem_to_reg=1.
- SW with mem_ready low for 2 cycles in MEMWR: state 5 held 3 cycles with mem_write=1 and iord=1 steady. instr_done on the third cycle, then FETCH.
- R-type: EXEC drives aluop=10, alu_src_a=1, alu_src_b=00. RTWB drives reg_write=1, reg_dst=1. Total 4 cycles.
- BEQ with zero=1 and zero=0: state 8 drives aluop=01, pc_write_cond=1, pc_source=01, pc_write=0. Then FETCH in both cases.
- Opcode 111111 (and 001000 when CTRL_ADDI_EN is undefined): DECODE shows illegal_op=1, instr_done=1, next state 0. With the macro defined, 001000 runs states 10, 11 with reg_write=1 in state 11.
- Reset asserted in MEMWR: state=0 immediately, mem_write=0 without waiting for a clock edge.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control path: opcodes, FSM
// state encodings, ALU/mux select codes and the decoded control bundle.
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_RTWB   = 4'd7,
      S_BEQ    = 4'd8,
      S_JUMP   = 4'd9,
      S_ADDIEX = 4'd10,
      S_ADDIWB = 4'd11
   } state_t;

   localparam logic [1:0] ALUOP_ADD  = 2'b00;
   localparam logic [1:0] ALUOP_SUB  = 2'b01;
   localparam logic [1:0] ALUOP_FUNC = 2'b10;

   localparam logic [1:0] SRCB_B       = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   // mem_wait marks states whose write enables and done pulse wait on mem_ready.
   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       ir_write;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] aluop;
      logic [1:0] pc_source;
      logic       instr_done;
      logic       mem_wait;
   } ctrl_out_t;

endpackage

// File: rtl/ctrl_output_decode.sv
// Pure state-to-output map for the multicycle controller. Handshake
// qualification and reset forcing live in the FSM top. Macro: CTRL_ADDI_EN.
module ctrl_output_decode
   import mips_pkg::*;
(
   input  state_t    state,
   output ctrl_out_t ctl
);

   always_comb begin
      // NOTE: a full default first means no path leaves a field unassigned, so no latch.
      ctl = '0;
      case (state)
         S_FETCH: begin
            ctl.mem_read   = 1'b1;
            ctl.alu_src_b  = SRCB_FOUR;
            ctl.aluop      = ALUOP_ADD;
            ctl.pc_source  = PCSRC_ALU;
            ctl.ir_write   = 1'b1;
            ctl.pc_write   = 1'b1;
            ctl.mem_wait   = 1'b1;
         end
         S_DECODE: begin
            ctl.alu_src_b  = SRCB_IMM_SH2;
            ctl.aluop      = ALUOP_ADD;
         end
         S_MEMADR: begin
            ctl.alu_src_a  = 1'b1;
            ctl.alu_src_b  = SRCB_IMM;
            ctl.aluop      = ALUOP_ADD;
         end
         S_MEMRD: begin
            ctl.mem_read   = 1'b1;
            ctl.iord       = 1'b1;
            ctl.mem_wait   = 1'b1;
         end
         S_MEMWB: begin
            ctl.reg_write  = 1'b1;
            ctl.mem_to_reg = 1'b1;
            ctl.instr_done = 1'b1;
         end
         S_MEMWR: begin
            ctl.mem_write  = 1'b1;
            ctl.iord       = 1'b1;
            ctl.instr_done = 1'b1;
            ctl.mem_wait   = 1'b1;
         end
         S_EXEC: begin
            ctl.alu_src_a  = 1'b1;
            ctl.alu_src_b  = SRCB_B;
            ctl.aluop      = ALUOP_FUNC;
         end
         S_RTWB: begin
            ctl.reg_write  = 1'b1;
            ctl.reg_dst    = 1'b1;
            ctl.instr_done = 1'b1;
         end
         S_BEQ: begin
            ctl.alu_src_a     = 1'b1;
            ctl.aluop         = ALUOP_SUB;
            ctl.pc_write_cond = 1'b1;
            ctl.pc_source     = PCSRC_ALUOUT;
            ctl.instr_done    = 1'b1;
         end
         S_JUMP: begin
            ctl.pc_write   = 1'b1;
            ctl.pc_source  = PCSRC_JUMP;
            ctl.instr_done = 1'b1;
         end
`ifdef CTRL_ADDI_EN
         S_ADDIEX: begin
            ctl.alu_src_a  = 1'b1;
            ctl.alu_src_b  = SRCB_IMM;
            ctl.aluop      = ALUOP_ADD;
         end
         S_ADDIWB: begin
            ctl.reg_write  = 1'b1;
            ctl.instr_done = 1'b1;
         end
`endif
         default: ctl = '0;
      endcase
   end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS datapath (Moore, registered state).
// Macro CTRL_ADDI_EN adds the ADDI execute/writeback states.
module mips_multicycle_ctrl
   import mips_pkg::*;
#(
   parameter int OPW = 6,
   parameter int STW = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [OPW-1:0] opcode,
   input  logic           zero,
   input  logic           mem_ready,
   output logic           pc_write,
   output logic           pc_write_cond,
   output logic           iord,
   output logic           mem_read,
   output logic           mem_write,
   output logic           mem_to_reg,
   output logic           ir_write,
   output logic           reg_dst,
   output logic           reg_write,
   output logic           alu_src_a,
   output logic [1:0]     alu_src_b,
   output logic [1:0]     aluop,
   output logic [1:0]     pc_source,
   output logic           instr_done,
   output logic           illegal_op,
   output logic [STW-1:0] state
);

   state_t    state_q, state_d;
   ctrl_out_t raw;
   logic      illegal;
   logic      mem_done;
   logic [5:0] op;

   assign op = opcode[5:0];

   // zero is consumed by the datapath together with pc_write_cond.
   wire unused_zero = zero;

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      if (!rst_n) state_q <= S_FETCH;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = S_FETCH;
      illegal = 1'b0;
      case (state_q)
         S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_EXEC;
               OP_BEQ:       state_d = S_BEQ;
               OP_J:         state_d = S_JUMP;
`ifdef CTRL_ADDI_EN
               OP_ADDI:      state_d = S_ADDIEX;
`endif
               default: begin
                  state_d = S_FETCH;
                  illegal = 1'b1;
               end
            endcase
         end
         S_MEMADR: state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
         S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
         S_EXEC:   state_d = S_RTWB;
`ifdef CTRL_ADDI_EN
         S_ADDIEX: state_d = S_ADDIWB;
`endif
         default:  state_d = S_FETCH;
      endcase
   end

   ctrl_output_decode u_decode (
      .state (state_q),
      .ctl   (raw)
   );

   // Memory-state enables and the done pulse only fire on the edge that completes the access.
   assign mem_done = ~raw.mem_wait | mem_ready;

   assign pc_write      = rst_n & raw.pc_write & mem_done;
   assign ir_write      = rst_n & raw.ir_write & mem_done;
   assign mem_write     = rst_n & raw.mem_write;
   assign reg_write     = rst_n & raw.reg_write;
   assign pc_write_cond = raw.pc_write_cond;
   assign iord          = raw.iord;
   assign mem_read      = raw.mem_read;
   assign mem_to_reg    = raw.mem_to_reg;
   assign reg_dst       = raw.reg_dst;
   assign alu_src_a     = raw.alu_src_a;
   assign alu_src_b     = raw.alu_src_b;
   assign aluop         = raw.aluop;
   assign pc_source     = raw.pc_source;
   assign instr_done    = (raw.instr_done & mem_done) | illegal;
   assign illegal_op    = illegal;
   assign state         = STW'(state_q);

endmodule
